// File: rtl/sin_cos_lut_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sin/cos generator between N_CH requesters.
// Results come back tagged with their channel through a credit-protected FWFT FIFO.
module sin_cos_lut_arbiter #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PHASE_W    = 12,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_CH-1:0]           i_req_valid,
  input  logic [N_CH*PHASE_W-1:0]   i_req_phase,
  output logic [N_CH-1:0]           o_req_ready,
  output logic                      o_gen_valid,
  output logic [PHASE_W-1:0]        o_gen_phase,
  input  logic [SAMPLE_W-1:0]       i_gen_sin,
  input  logic [SAMPLE_W-1:0]       i_gen_cos,
  output logic                      o_res_valid,
  output logic [$clog2(N_CH)-1:0]   o_res_ch,
  output logic [SAMPLE_W-1:0]       o_res_sin,
  output logic [SAMPLE_W-1:0]       o_res_cos,
  input  logic                      i_res_ready,
  output logic                      o_overflow
);

  localparam int unsigned CH_W   = $clog2(N_CH);
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic [N_CH-1:0]    grant;
  logic               grant_any;
  logic [CH_W-1:0]    grant_ch;
  logic [PHASE_W-1:0] grant_phase;

  logic               gen_valid_q;
  logic [PHASE_W-1:0] gen_phase_q;
  logic [CH_W-1:0]    gen_ch_q;

  logic [LATENCY-1:0] dl_valid_q;
  logic [CH_W-1:0]    dl_ch_q [LATENCY];

  logic [CH_W-1:0]     mem_ch_q  [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_sin_q [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_cos_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CRED_W-1:0]   count_q, count_d;
  logic                overflow_q;
  logic                wr, full, pop, wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Rotating priority search from ptr_q; blocked entirely when no credit is held.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_ch  = '0;
    if (credits_q != '0) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        idx = (int'(ptr_q) + i) % N_CH;
        if (!grant_any && i_req_valid[idx]) begin
          grant_any = 1'b1;
          grant_ch  = CH_W'(idx);
        end
      end
    end
    grant           = '0;
    grant[grant_ch] = grant_any;
  end

  assign grant_phase = i_req_phase[grant_ch*PHASE_W +: PHASE_W];
  assign o_req_ready = grant & {N_CH{i_rst_n}};

  assign wr    = dl_valid_q[LATENCY-1];
  assign full  = (count_q == CRED_W'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && i_res_ready;
  assign wr_en = wr && (!full || pop);

  always_comb begin
    ptr_d     = ptr_q;
    credits_d = credits_q - CRED_W'(grant_any) + CRED_W'(pop);
    count_d   = count_q + CRED_W'(wr_en) - CRED_W'(pop);
    if (grant_any) begin
      ptr_d = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      credits_q   <= CRED_W'(FIFO_DEPTH);
      gen_valid_q <= 1'b0;
      gen_phase_q <= '0;
      gen_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      credits_q   <= credits_d;
      gen_valid_q <= grant_any;
      if (grant_any) begin
        gen_phase_q <= grant_phase;
        gen_ch_q    <= grant_ch;
      end
    end
  end

  // Tag pipeline aligned so the last stage lines up with the generator output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl_valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) dl_ch_q[i] <= '0;
    end else begin
      dl_valid_q[0] <= gen_valid_q;
      dl_ch_q[0]    <= gen_ch_q;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_ch_q[i]    <= dl_ch_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_ch_q[i]  <= '0;
        mem_sin_q[i] <= '0;
        mem_cos_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (wr && full) overflow_q <= 1'b1;
      if (wr_en) begin
        mem_ch_q[wr_ptr_q]  <= dl_ch_q[LATENCY-1];
        mem_sin_q[wr_ptr_q] <= i_gen_sin;
        mem_cos_q[wr_ptr_q] <= i_gen_cos;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign o_gen_valid = gen_valid_q;
  assign o_gen_phase = gen_phase_q;
  assign o_res_valid = (count_q != '0);
  assign o_res_ch    = mem_ch_q[rd_ptr_q];
  assign o_res_sin   = mem_sin_q[rd_ptr_q];
  assign o_res_cos   = mem_cos_q[rd_ptr_q];
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_sin_cos_lut_arbiter.sv
// Randomized bench for sin_cos_lut_arbiter: a queue-based transaction model predicts grants,
// issue and tagged results cycle by cycle; a behavioural sin/cos generator closes the loop.
module tb_sin_cos_lut_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned PW  = 12;
  localparam int unsigned SW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;
  localparam int unsigned CHW = $clog2(N);

  localparam int MIdle  = 0;
  localparam int MAll   = 1;
  localparam int MStall = 2;
  localparam int MRand  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*PW-1:0]   req_phase;
  logic [N-1:0]      req_ready;
  logic              gen_valid;
  logic [PW-1:0]     gen_phase;
  logic [SW-1:0]     gen_sin, gen_cos;
  logic              res_valid;
  logic [CHW-1:0]    res_ch;
  logic [SW-1:0]     res_sin, res_cos;
  logic              res_ready;
  logic              overflow;

  sin_cos_lut_arbiter #(
    .N_CH(N), .PHASE_W(PW), .SAMPLE_W(SW), .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_phase(req_phase), .o_req_ready(req_ready),
    .o_gen_valid(gen_valid), .o_gen_phase(gen_phase),
    .i_gen_sin(gen_sin), .i_gen_cos(gen_cos),
    .o_res_valid(res_valid), .o_res_ch(res_ch), .o_res_sin(res_sin), .o_res_cos(res_cos),
    .i_res_ready(res_ready), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] f_sin(input logic [PW-1:0] p);
    real a;
    a = 6.283185307179586 * real'(p) / real'(1 << PW);
    return SW'(int'(32767.0 * $sin(a)));
  endfunction

  function automatic logic [SW-1:0] f_cos(input logic [PW-1:0] p);
    real a;
    a = 6.283185307179586 * real'(p) / real'(1 << PW);
    return SW'(int'(32767.0 * $cos(a)));
  endfunction

  // Generator with LAT cycles of latency from o_gen_phase.
  logic [PW-1:0] gen_pipe [LAT];
  always @(posedge clk) begin
    gen_pipe[0] <= gen_phase;
    for (int i = 1; i < LAT; i++) gen_pipe[i] <= gen_pipe[i-1];
  end
  assign gen_sin = f_sin(gen_pipe[LAT-1]);
  assign gen_cos = f_cos(gen_pipe[LAT-1]);

  typedef struct {
    int            ch;
    logic [PW-1:0] phase;
    int            due;
  } ent_t;

  ent_t          q[$];
  int            credits, ptr, cyc;
  bit            prev_gv;
  logic [PW-1:0] last_phase;
  bit            hold_valid [N];
  logic [PW-1:0] hold_phase [N];
  int            n_vec  = 0;
  int            n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    credits    = FD;
    ptr        = 0;
    prev_gv    = 1'b0;
    last_phase = '0;
    for (int k = 0; k < N; k++) hold_valid[k] = 1'b0;
  endtask

  task automatic drive(input int mode);
    for (int k = 0; k < N; k++) begin
      bit want;
      want = (mode == MAll || mode == MStall) ? 1'b1 :
             (mode == MRand) ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (!hold_valid[k] && want) begin
        hold_valid[k] = 1'b1;
        hold_phase[k] = PW'($urandom);
      end
      req_valid[k]            = hold_valid[k];
      req_phase[k*PW +: PW]   = hold_phase[k];
    end
    res_ready = (mode == MStall) ? 1'b0 :
                (mode == MRand)  ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Compare this cycle's outputs with the model, then advance the model across the edge.
  task automatic step();
    bit            exp_rv;
    int            g;
    logic [N-1:0]  exp_ready;
    exp_rv = (q.size() > 0) && (q[0].due <= cyc);
    check_eq("res_valid", 64'(res_valid), 64'(exp_rv));
    if (exp_rv) begin
      check_eq("res_ch",  64'(res_ch),  64'(q[0].ch));
      check_eq("res_sin", 64'(res_sin), 64'(f_sin(q[0].phase)));
      check_eq("res_cos", 64'(res_cos), 64'(f_cos(q[0].phase)));
    end
    g = -1;
    if (credits > 0) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && hold_valid[(ptr + i) % N]) g = (ptr + i) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    check_eq("gen_valid", 64'(gen_valid), 64'(prev_gv));
    check_eq("gen_phase", 64'(gen_phase), 64'(last_phase));
    check_eq("overflow",  64'(overflow),  64'(0));
    if (exp_rv && res_ready) begin
      void'(q.pop_front());
      credits++;
    end
    if (g >= 0) begin
      q.push_back('{ch: g, phase: hold_phase[g], due: cyc + LAT + 2});
      credits--;
      ptr           = (g + 1) % N;
      hold_valid[g] = 1'b0;
      prev_gv       = 1'b1;
      last_phase    = hold_phase[g];
    end else begin
      prev_gv = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      drive(mode);
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check_eq({tag, "_gen_valid"}, 64'(gen_valid), 64'(0));
    check_eq({tag, "_gen_phase"}, 64'(gen_phase), 64'(0));
    check_eq({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, "_res_sin"},   64'(res_sin),   64'(0));
    check_eq({tag, "_overflow"},  64'(overflow),  64'(0));
  endtask

  task automatic mid_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = '1;
    req_phase = '0;
    res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single request: ch0 at a quarter turn.
    hold_valid[0] = 1'b1;
    hold_phase[0] = PW'(1024);
    run(MIdle, 8);

    // Pointer lands past ch2, so ch3 must beat ch1.
    hold_valid[2] = 1'b1;
    hold_phase[2] = PW'($urandom);
    run(MIdle, 6);
    hold_valid[1] = 1'b1;
    hold_phase[1] = PW'($urandom);
    hold_valid[3] = 1'b1;
    hold_phase[3] = PW'($urandom);
    run(MIdle, 8);

    run(MAll, 30);
    run(MStall, 12);
    run(MAll, 12);
    run(MRand, 200);

    // Reset with results in flight and queued.
    run(MStall, 3);
    run(MAll, 3);
    mid_reset();
    run(MRand, 30);
    run(MStall, 10);
    run(MRand, 200);
    run(MIdle, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
